uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter CLK_PER_BIT, default 868 (100 MHz / 115200 baud): clk cycles per serial bit; legal range >= 2.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rdy  input  1  producer (fifo read side) has a word on data.
REQ-006 SHALL have port data  input  WIDTH  word to transmit; valid while rdy=1.
REQ-007 SHALL have port done  output  1  word taken; acknowledge to producer.
REQ-008 SHALL have port tx  output  1  serial line; idle high.
REQ-009 SHALL have port busy  output  1  frame in progress (state != IDLE).

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-011 SHALL accept a word on the edge where state=IDLE, rdy=1, done=0: load data into shift register, done<=1, state<=START, tx<=0.
REQ-012 SHALL hold done=1 until rdy=0 is sampled, then clear done on that edge, independent of frame progress.
REQ-013 SHALL NOT accept a new word while done=1 or state!=IDLE; rdy/data are ignored then.
REQ-014 SHALL drive each of start bit (0), WIDTH data bits (LSB first), parity bit (if enabled) and stop bit (1) for exactly CLK_PER_BIT cycles.
REQ-015 SHALL use a baud counter of width $clog2(CLK_PER_BIT), cleared on every bit transition, advancing the bit at count CLK_PER_BIT-1.
REQ-016 SHALL use a bit index counter counting 0..WIDTH-1 in DATA, moving to PARITY/STOP after index WIDTH-1 completes.
REQ-017 SHALL return to IDLE with tx=1 after the stop bit; frame length (WIDTH+2)*CLK_PER_BIT cycles, +CLK_PER_BIT with parity.
REQ-018 SHALL spend at least one cycle in IDLE between frames; back-to-back words give start bit one cycle after stop bit ends.
REQ-019 SHALL never change tx except at bit boundaries or reset; no glitches mid-bit.

Reset
REQ-020 SHALL on rst=1 set tx=1, done=0, busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0 at the next edge.
REQ-021 SHALL on reset mid-frame abandon the frame (tx high next edge) and lose the word; rst has priority over all other inputs.
REQ-022 SHALL on reset with done=1 clear done; producer re-handshakes from rdy.

Configuration
REQ-023 SHALL, when macro UART_TX_PARITY_EN is defined, insert PARITY state sending even parity (XOR of the WIDTH data bits) between last data bit and stop bit.
REQ-024 SHALL, when UART_TX_PARITY_EN is undefined, contain no PARITY state or parity logic; DATA proceeds directly to STOP.

Verification (CLK_PER_BIT=4, WIDTH=8)
REQ-025 SHALL cover single word: rdy=1, data=0xA5 -> done=1 next cycle; tx = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; busy low after 40 cycles.
REQ-026 SHALL cover handshake hold: rdy held high 10 cycles after done -> done stays 1 throughout, clears on edge after rdy=0 sampled; no second capture.
REQ-027 SHALL cover back-to-back: fifo with 0x00 then 0xFF queued -> two frames, exactly 1 idle cycle (tx=1) between stop bit of first and start bit of second.
REQ-028 SHALL cover reset mid-frame: rst=1 during bit 3 of 0x3C -> tx=1, busy=0, done=0 next edge; next word 0x81 sends cleanly.
REQ-029 SHALL cover parity (UART_TX_PARITY_EN defined): data=0x07 -> parity bit 1, frame 44 cycles; data=0x03 -> parity bit 0.
REQ-030 SHALL cover fifo integration: write 20 words into fifo, uart_tx drains all; decoded serial stream equals write order, fifo empty=1 at end.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, 8N1-style framing (start, WIDTH data bits LSB first, stop).
// Takes words from a producer through a rdy/done handshake. The handshake rule:
// a word is taken on the edge where the FSM is IDLE, rdy=1 and done=0. done then
// stays high until rdy=0 is sampled, and it clears on that edge whatever the frame is doing.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit between the last data bit and the stop bit.
module uart_tx #(
    parameter int WIDTH       = 8,
    parameter int CLK_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [WIDTH-1:0] data,
    output logic             done,
    output logic             tx,
    output logic             busy
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             bit_end;
    logic [WIDTH-1:0] shift_nxt;

    assign bit_end   = (baud_q == CNT_LAST);
    assign shift_nxt = shift_q >> 1;

    // Next-state logic: tx is registered and only reloaded at bit boundaries.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = done_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        // done drops once the producer withdraws rdy, independent of the frame.
        if (done_q && !rdy) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                idx_d  = '0;
                tx_d   = 1'b1;
                if (rdy && !done_q) begin
                    shift_d = data;
                    done_d  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[0];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                baud_d  = '0;
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any frame and drops the pending acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with WIDTH=8, CLK_PER_BIT=4.
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that produced them.
module tb_uart_tx;

    localparam int WIDTH = 8;
    localparam int CPB   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB    = WIDTH + 3;
`else
    localparam int NB    = WIDTH + 2;
`endif
    localparam int FRAME = NB * CPB;

    logic             clk;
    logic             rst;
    logic             rdy;
    logic [WIDTH-1:0] data;
    logic             done;
    logic             tx;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] fifo_q[$];

    uart_tx #(.WIDTH(WIDTH), .CLK_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .rdy  (rdy),
        .data (data),
        .done (done),
        .tx   (tx),
        .busy (busy)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word; returns at the falling edge after the capture edge.
    task automatic send(input logic [WIDTH-1:0] d);
        rdy  = 1'b1;
        data = d;
        @(negedge clk);
    endtask

    // Check ncyc cycles of the frame for d, starting just after the capture edge.
    // rdy is held (with scrambled data) for 'hold' cycles after capture; if nxt is
    // set, the next word is presented during the last stop-bit cycle.
    task automatic check_frame(input string tag, input logic [WIDTH-1:0] d, input int hold,
                               input int ncyc, input bit nxt, input logic [WIDTH-1:0] nxt_d,
                               output logic [WIDTH-1:0] got);
        logic [NB-1:0] bits;
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, ^d, d, 1'b0};
`else
        bits = {1'b1, d, 1'b0};
`endif
        got = '0;
        for (int c = 0; c < ncyc; c++) begin
            check($sformatf("%s_tx_c%0d", tag, c), {31'd0, tx}, {31'd0, bits[c / CPB]});
            check($sformatf("%s_done_c%0d", tag, c), {31'd0, done}, (c <= hold) ? 32'd1 : 32'd0);
            check($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy}, 32'd1);
            if (c >= CPB && c < CPB * (WIDTH + 1) && (c % CPB) == CPB / 2) begin
                got[c / CPB - 1] = tx;
            end
            rdy = (c < hold);
            if (c < hold) data = ~d;
            if (nxt && c == FRAME - 1) begin
                rdy  = 1'b1;
                data = nxt_d;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nd;
        bit               nxt;

        // Reset state
        rst  = 1'b1;
        rdy  = 1'b0;
        data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single word 0xA5: tx = 0,1,0,1,0,0,1,0,1,1 each for 4 cycles
        send(8'hA5);
        check_frame("a5", 8'hA5, 0, FRAME, 1'b0, '0, got);
        check("a5_word", {24'd0, got}, 32'h0000_00A5);
        check("a5_end_busy", {31'd0, busy}, 32'd0);
        check("a5_end_tx", {31'd0, tx}, 32'd1);

        // Handshake hold: rdy high 10 cycles after capture, no second capture
        @(negedge clk);
        send(8'h5A);
        check_frame("hold", 8'h5A, 10, FRAME, 1'b0, '0, got);
        check("hold_word", {24'd0, got}, 32'h0000_005A);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold_after_busy%0d", i), {31'd0, busy}, 32'd0);
            check($sformatf("hold_after_tx%0d", i), {31'd0, tx}, 32'd1);
            @(negedge clk);
        end

        // Back-to-back 0x00 then 0xFF: exactly one idle cycle between frames
        send(8'h00);
        check_frame("b2b0", 8'h00, 0, FRAME, 1'b1, 8'hFF, got);
        check("b2b0_word", {24'd0, got}, 32'h0000_0000);
        check("b2b_gap_tx", {31'd0, tx}, 32'd1);
        check("b2b_gap_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_frame("b2b1", 8'hFF, 0, FRAME, 1'b0, '0, got);
        check("b2b1_word", {24'd0, got}, 32'h0000_00FF);

        // Reset during data bit 3 of 0x3C while done=1 and rdy=1
        @(negedge clk);
        send(8'h3C);
        check_frame("rst3c", 8'h3C, 30, CPB * 4 + 2, 1'b0, '0, got);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        rdy = 1'b0;
        @(negedge clk);
        check("postrst_busy", {31'd0, busy}, 32'd0);
        check("postrst_tx", {31'd0, tx}, 32'd1);
        send(8'h81);
        check_frame("w81", 8'h81, 0, FRAME, 1'b0, '0, got);
        check("w81_word", {24'd0, got}, 32'h0000_0081);
        check("w81_end_busy", {31'd0, busy}, 32'd0);

`ifdef UART_TX_PARITY_EN
        // Parity: 0x07 -> parity 1, 0x03 -> parity 0 (checked via bit pattern, 44 cycles)
        @(negedge clk);
        send(8'h07);
        check_frame("par07", 8'h07, 0, FRAME, 1'b0, '0, got);
        check("par07_end_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        send(8'h03);
        check_frame("par03", 8'h03, 0, FRAME, 1'b0, '0, got);
        check("par03_end_busy", {31'd0, busy}, 32'd0);
`endif

        // FIFO drain: 20 words, producer presents the next word as soon as possible
        for (int i = 0; i < 20; i++) begin
            fifo_q.push_back(WIDTH'((i * 37 + 11) % 256));
            exp_q.push_back(WIDTH'((i * 37 + 11) % 256));
        end
        @(negedge clk);
        cur = fifo_q.pop_front();
        send(cur);
        for (int i = 0; i < 20; i++) begin
            nxt = (fifo_q.size() > 0);
            nd  = nxt ? fifo_q[0] : '0;
            check_frame($sformatf("fifo%0d", i), cur, 0, FRAME, nxt, nd, got);
            check($sformatf("fifo%0d_word", i), {24'd0, got}, {24'd0, exp_q.pop_front()});
            check($sformatf("fifo%0d_gap_tx", i), {31'd0, tx}, 32'd1);
            check($sformatf("fifo%0d_gap_busy", i), {31'd0, busy}, 32'd0);
            if (nxt) begin
                cur = fifo_q.pop_front();
                @(negedge clk);
            end
        end
        rdy = 1'b0;
        check("fifo_empty", fifo_q.size(), 32'd0);
        check("fifo_all_seen", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
